// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared types and width defaults for the unified memory
//               arbiter: response-owner state encoding, requester ids and
//               default address/data/counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    // Owner of the read response due in the current cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_e;

    // Requester identity, used for the last-granted round-robin record.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

endpackage : riscv_mem_pkg
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Two-requester (fetch / data) arbiter in front of a single
//               port synchronous memory with one-cycle read latency.
//               Round-robin on conflict, combinational grant and memory
//               drive, registered response routing, saturating count of
//               conflict cycles.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               if_*                  - instruction fetch request/response
//               d_*                   - data load/store request/response
//               mem_*                 - memory port (rdata valid 1 cycle
//                                       after a read enable)
//               conflict_cnt, busy    - status
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    resp_state_e      state;
    resp_state_e      state_next;
    req_id_e          last_gnt;
    logic [CNT_W-1:0] cnt;
    logic             conflict;
    logic             grant_if;
    logic             grant_d;

    // Data wins a conflict whenever fetch was the most recent grant; the
    // reset value of last_gnt (REQ_IF) therefore hands data the first one.
    always_comb begin
        conflict = ~reset & if_req & d_req;
        grant_d  = ~reset & d_req & (~if_req | (last_gnt == REQ_IF));
        grant_if = ~reset & if_req & ~grant_d;
    end

    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        mem_en    = grant_if | grant_d;
        mem_we    = grant_d & d_we;
        mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
        mem_wdata = grant_d ? d_wdata : '0;
    end

    // Stores complete in the grant cycle, so only loads and fetches leave a
    // response pending for the next cycle.
    always_comb begin
        state_next = IDLE;
        if (grant_if) begin
            state_next = RESP_I;
        end else if (grant_d && !d_we) begin
            state_next = RESP_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= REQ_IF;
            cnt      <= '0;
        end else begin
            state <= state_next;
            if (grant_if) begin
                last_gnt <= REQ_IF;
            end else if (grant_d) begin
                last_gnt <= REQ_D;
            end
            if (conflict && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Outputs are masked by reset so that a response pending when reset
    // asserts is dropped in the reset cycle itself, not one cycle later.
    always_comb begin
        if_rvalid    = ~reset & (state == RESP_I);
        d_rvalid     = ~reset & (state == RESP_D);
        if_rdata     = if_rvalid ? mem_rdata : '0;
        d_rdata      = d_rvalid  ? mem_rdata : '0;
        busy         = if_rvalid | d_rvalid;
        conflict_cnt = reset ? '0 : cnt;
    end

endmodule : unified_mem_arbiter
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Self-checking bench for unified_mem_arbiter (CNT_W = 4):
//               directed vector table, counter saturation sequence and a
//               randomized run against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] conflict_cnt;
    logic          busy;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic drive(input bit rst, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dwe, input logic [31:0] da,
                         input logic [31:0] dw, input logic [31:0] mr);
        reset     = rst;
        if_req    = ir;
        if_addr   = ia;
        d_req     = dr;
        d_we      = dwe;
        d_addr    = da;
        d_wdata   = dw;
        mem_rdata = mr;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          rst;
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dw;
        logic [31:0] mr;
        bit          e_ig;
        bit          e_dg;
        bit          e_men;
        bit          e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        bit          e_iv;
        bit          e_dv;
        logic [31:0] e_rdata;
        bit          e_busy;
        int          e_cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    // ------------------------------------------------------------------
    // Behavioural model: who was served last, which response is due this
    // cycle (0 none, 1 fetch, 2 load) and how many conflicts were seen.
    // ------------------------------------------------------------------
    bit m_last_fetch = 1'b1;
    int m_due        = 0;
    int m_cnt        = 0;

    task automatic mstep(input bit rst, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dwe, input logic [31:0] da,
                         input logic [31:0] dw, input logic [31:0] mr,
                         output bit pi, output bit pd);
        bit          iv, dv, men, mwe, bz;
        logic [31:0] maddr, mwdata;
        int          cnt;
        pi = 1'b0;
        pd = 1'b0;
        if (!rst) begin
            if (ir && dr) pd = m_last_fetch;
            else          pd = dr;
            pi = ir && !pd;
        end
        men    = pi || pd;
        mwe    = pd && dwe;
        maddr  = pd ? da : (pi ? ia : 32'h0);
        mwdata = pd ? dw : 32'h0;
        iv     = !rst && (m_due == 1);
        dv     = !rst && (m_due == 2);
        bz     = iv || dv;
        cnt    = rst ? 0 : m_cnt;

        drive(rst, ir, ia, dr, dwe, da, dw, mr);
        #2;
        chk("rnd_gnt",      {62'b0, if_gnt, d_gnt}, {62'b0, pi, pd});
        chk("rnd_mem_ctl",  {62'b0, mem_en, mem_we}, {62'b0, men, mwe});
        chk("rnd_mem_addr", {32'b0, mem_addr}, {32'b0, maddr});
        chk("rnd_mem_wdata",{32'b0, mem_wdata}, {32'b0, mwdata});
        chk("rnd_rvalid",   {62'b0, if_rvalid, d_rvalid}, {62'b0, iv, dv});
        chk("rnd_if_rdata", {32'b0, if_rdata}, {32'b0, (iv ? mr : 32'h0)});
        chk("rnd_d_rdata",  {32'b0, d_rdata}, {32'b0, (dv ? mr : 32'h0)});
        chk("rnd_busy",     {63'b0, busy}, {63'b0, bz});
        chk("rnd_cnt",      {60'b0, conflict_cnt}, 64'(cnt));
        @(posedge clk);
        #1;
        if (rst) begin
            m_last_fetch = 1'b1;
            m_due        = 0;
            m_cnt        = 0;
        end else begin
            m_due = pi ? 1 : ((pd && !dwe) ? 2 : 0);
            if (pi) m_last_fetch = 1'b1;
            if (pd) m_last_fetch = 1'b0;
            if (ir && dr && m_cnt < (1 << CW) - 1) m_cnt++;
        end
    endtask

    bit          hi, hd, hwe, pi, pd, rst;
    logic [31:0] hia, hda, hdw;

    initial begin
        tbl[0]  = '{1,0,0,0,0,0,0,0,                       0,0,0,0,0,0,                 0,0,0,0,0};
        tbl[1]  = '{0,1,32'h10,0,0,0,0,0,                  1,0,1,0,32'h10,0,            0,0,0,0,0};
        tbl[2]  = '{0,0,0,0,0,0,0,32'h00500093,            0,0,0,0,0,0,                 1,0,32'h00500093,1,0};
        tbl[3]  = '{0,0,0,0,0,0,0,32'h77,                  0,0,0,0,0,0,                 0,0,0,0,0};
        tbl[4]  = '{0,0,0,1,1,32'h40,32'hDEADBEEF,0,       0,1,1,1,32'h40,32'hDEADBEEF, 0,0,0,0,0};
        tbl[5]  = '{0,0,0,0,0,0,0,32'h1234,                0,0,0,0,0,0,                 0,0,0,0,0};
        tbl[6]  = '{0,0,0,1,0,32'h80,0,0,                  0,1,1,0,32'h80,0,            0,0,0,0,0};
        tbl[7]  = '{0,1,32'h14,0,0,0,0,32'hCAFEF00D,       1,0,1,0,32'h14,0,            0,1,32'hCAFEF00D,1,0};
        tbl[8]  = '{0,0,0,0,0,0,0,32'h11112222,            0,0,0,0,0,0,                 1,0,32'h11112222,1,0};
        tbl[9]  = '{1,0,0,0,0,0,0,32'h99,                  0,0,0,0,0,0,                 0,0,0,0,0};
        tbl[10] = '{0,1,32'h100,1,0,32'h200,0,0,           0,1,1,0,32'h200,0,           0,0,0,0,0};
        tbl[11] = '{0,1,32'h100,1,0,32'h200,0,32'hA1,      1,0,1,0,32'h100,0,           0,1,32'hA1,1,1};
        tbl[12] = '{0,1,32'h100,1,0,32'h200,0,32'hA2,      0,1,1,0,32'h200,0,           1,0,32'hA2,1,2};
        tbl[13] = '{0,0,0,0,0,0,0,32'hA3,                  0,0,0,0,0,0,                 0,1,32'hA3,1,3};
        tbl[14] = '{0,1,32'h20,0,0,0,0,0,                  1,0,1,0,32'h20,0,            0,0,0,0,3};
        tbl[15] = '{1,0,0,0,0,0,0,32'h5555,                0,0,0,0,0,0,                 0,0,0,0,0};
        tbl[16] = '{0,0,0,0,0,0,0,32'h6666,                0,0,0,0,0,0,                 0,0,0,0,0};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dwe,
                  tbl[i].da, tbl[i].dw, tbl[i].mr);
            #2;
            chk($sformatf("v%0d_gnt", i), {62'b0, if_gnt, d_gnt}, {62'b0, tbl[i].e_ig, tbl[i].e_dg});
            chk($sformatf("v%0d_mem_ctl", i), {62'b0, mem_en, mem_we}, {62'b0, tbl[i].e_men, tbl[i].e_mwe});
            chk($sformatf("v%0d_mem_data", i), {mem_addr, mem_wdata}, {tbl[i].e_maddr, tbl[i].e_mwdata});
            chk($sformatf("v%0d_rvalid", i), {62'b0, if_rvalid, d_rvalid}, {62'b0, tbl[i].e_iv, tbl[i].e_dv});
            chk($sformatf("v%0d_rdata", i), {if_rdata, d_rdata},
                {(tbl[i].e_iv ? tbl[i].e_rdata : 32'h0), (tbl[i].e_dv ? tbl[i].e_rdata : 32'h0)});
            chk($sformatf("v%0d_busy", i), {63'b0, busy}, {63'b0, tbl[i].e_busy});
            chk($sformatf("v%0d_cnt", i), {60'b0, conflict_cnt}, 64'(tbl[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Saturation: 20 conflict cycles must leave the 4-bit count at 15.
        mstep(1, 0, 0, 0, 0, 0, 0, 0, pi, pd);
        for (int i = 0; i < 20; i++) begin
            mstep(0, 1, 32'h300, 1, 0, 32'h400, 0, 32'(i), pi, pd);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("sat_cnt_20", {60'b0, conflict_cnt}, 64'd15);
        @(posedge clk);
        #1;
        m_due = 0;
        for (int i = 0; i < 4; i++) begin
            mstep(0, 1, 32'h304, 1, 1, 32'h404, 32'h5, 0, pi, pd);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("sat_cnt_hold", {60'b0, conflict_cnt}, 64'd15);
        @(posedge clk);
        #1;
        m_due = 0;

        // Randomized traffic; requests are held until granted.
        mstep(1, 0, 0, 0, 0, 0, 0, 0, pi, pd);
        hi = 0;
        hd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hi && $urandom_range(0, 1) == 1) begin
                hi  = 1;
                hia = $urandom;
            end
            if (!hd && $urandom_range(0, 1) == 1) begin
                hd  = 1;
                hwe = $urandom_range(0, 1) == 1;
                hda = $urandom;
                hdw = $urandom;
            end
            rst = ($urandom_range(0, 39) == 0);
            mstep(rst, hi, hia, hd, hwe, hda, hdw, $urandom, pi, pd);
            if (pi || rst) hi = 0;
            if (pd || rst) hd = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_unified_mem_arbiter
`default_nettype wire

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width | DATA_W, 32, data width | CNT_W, 16, conflict counter width.
REQ-002 SHALL have ports, clock and reset first: clk in 1 system clock | reset in 1 synchronous active-high reset.
REQ-003 SHALL have fetch ports: if_req in 1 fetch request | if_addr in ADDR_W fetch address | if_gnt out 1 fetch granted this cycle | if_rvalid out 1 fetch data valid | if_rdata out DATA_W fetched instruction.
REQ-004 SHALL have data ports: d_req in 1 data request | d_we in 1 store=1/load=0 | d_addr in ADDR_W data address | d_wdata in DATA_W store data | d_gnt out 1 data granted | d_rvalid out 1 load data valid | d_rdata out DATA_W load data.
REQ-005 SHALL have memory ports: mem_en out 1 access enable | mem_we out 1 write enable | mem_addr out ADDR_W address | mem_wdata out DATA_W write data | mem_rdata in DATA_W read data, valid one cycle after a read enable.
REQ-006 SHALL have status ports: conflict_cnt out CNT_W saturating count of conflict cycles | busy out 1 read response pending.
REQ-007 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-008 SHALL issue at most one memory access per cycle; mem_* are combinational from the granted requester's inputs in the grant cycle.
REQ-009 SHALL assert x_gnt combinationally in the cycle the access is placed on mem_*; a requester holds req and its address/data stable until it sees gnt.
REQ-010 SHALL grant the sole requester when only one of if_req/d_req is high.
REQ-011 SHALL, on a conflict (both high), grant the requester not granted most recently; after reset, data wins the first conflict.
REQ-012 SHALL update the last-granted register on every grant, conflict or not.
REQ-013 SHALL assert if_rvalid exactly one cycle after an if_gnt, with if_rdata = mem_rdata in that cycle.
REQ-014 SHALL assert d_rvalid exactly one cycle after a d_gnt with d_we=0; stores produce no d_rvalid.
REQ-015 SHALL support back-to-back grants every cycle, so a response and a new grant coexist in one cycle.
REQ-016 SHALL drive mem_en=0, mem_we=0 and both gnt=0 when neither requester requests.
REQ-017 SHALL drive if_rdata/d_rdata to 0 whenever the matching rvalid is 0.
REQ-018 SHALL track the response owner in a one-cycle state: IDLE, RESP_I or RESP_D. RESP_I follows an if_gnt; RESP_D follows a load d_gnt; otherwise IDLE. busy=1 in RESP_I and RESP_D.
REQ-019 SHALL increment conflict_cnt by 1 per conflict cycle and hold it at all-ones; no wrap.

Reset
REQ-020 SHALL, while reset=1, force state=IDLE, last-granted=fetch (so data wins next), conflict_cnt=0, and all gnt, rvalid, mem_en, mem_we and busy outputs to 0.
REQ-021 SHALL discard a response pending when reset asserts; no rvalid appears in the cycle after reset deasserts.
REQ-022 SHALL accept a first grant in the first cycle with reset=0.

Structure
REQ-023 SHALL place the state enum (IDLE/RESP_I/RESP_D), the requester-id enum (REQ_IF/REQ_D) and the width defaults in a shared package, riscv_mem_pkg.
REQ-024 SHALL be a single module with no sub-modules. The round-robin pick is inline logic; no arbiter sub-module is needed for two requesters.

Verification
REQ-025 SHALL cover the fetch-only case: if_req=1, if_addr=0x10, mem_rdata=0x00500093 next cycle -> if_gnt=1 in the same cycle, if_rvalid=1 and if_rdata=0x00500093 one cycle later.
REQ-026 SHALL cover a conflict right after reset: both req=1 for 3 cycles -> grants D, I, D; conflict_cnt=3.
REQ-027 SHALL cover a store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 with those values, d_gnt=1, and no d_rvalid the next cycle.
REQ-028 SHALL cover a back-to-back load then fetch: a load from 0x80 followed by a fetch from 0x14 -> d_rvalid in cycle 2 together with if_gnt, and if_rvalid in cycle 3.
REQ-029 SHALL cover reset mid-operation: reset=1 in the cycle after an if_gnt -> if_rvalid=0, busy=0 and conflict_cnt=0.
REQ-030 SHALL cover saturation with CNT_W=4: 20 conflict cycles -> conflict_cnt=15 and it holds at 15.
